accumulator: RTL

ACCUMULATOR -- requirements
Module: accumulator

---
 rtl/accumulator_pkg.sv | 4 +
 rtl/accumulator_adder.sv | 14 +
 rtl/accumulator.sv | 79 +++++++
 3 files changed

// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared state encoding for the accumulator
package accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/accumulator_adder.sv
// adder: signed a+b with one guard bit, arithmetically scaled down by OUT_SCALE (assumes A_WIDTH >= B_WIDTH)
module adder #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 17,
  parameter int OUT_SCALE = 0
) (
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic signed [A_WIDTH:0]   sum
);
  logic signed [A_WIDTH:0] full;
  assign full = (A_WIDTH+1)'(a) + (A_WIDTH+1)'(b);
  assign sum = full >>> OUT_SCALE;
endmodule

// File: rtl/accumulator.sv
// accumulator: sums cfg_len signed terms into one result; define ACCUMULATOR_SAT_EN to clamp instead of wrap
module accumulator
  import accumulator_pkg::*;
#(
  parameter int IN_WIDTH = 17,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_sat
);
  state_t state, state_n;
  logic signed [ACC_WIDTH-1:0] acc, acc_n, upd;
  logic signed [ACC_WIDTH:0] sum;
  logic [LEN_WIDTH-1:0] cnt, cnt_n, len, len_n;
  logic sat, sat_n, ovf;
  adder #(.A_WIDTH(ACC_WIDTH), .B_WIDTH(IN_WIDTH), .OUT_SCALE(0)) u_add (
    .a(acc), .b(in_data), .sum(sum)
  );
`ifdef ACCUMULATOR_SAT_EN
  // guard bit disagreeing with the sign bit means the true sum left the ACC_WIDTH range
  assign ovf = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
  assign upd = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
`else
  assign ovf = 1'b0;
  assign upd = ACC_WIDTH'(sum);
`endif
  assign in_ready = state != HOLD;
  assign out_valid = state == HOLD;
  assign out_data = acc;
  assign out_sat = sat;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    len_n = len;
    sat_n = sat;
    case (state)
      IDLE: if (in_valid) begin
        acc_n = ACC_WIDTH'(in_data);
        cnt_n = LEN_WIDTH'(1);
        len_n = cfg_len == '0 ? LEN_WIDTH'(1) : cfg_len;
        sat_n = 1'b0;
        state_n = len_n == LEN_WIDTH'(1) ? HOLD : ACCUM;
      end
      ACCUM: if (in_valid) begin
        acc_n = upd;
        cnt_n = cnt + 1'b1;
        sat_n = sat | ovf;
        state_n = cnt_n == len ? HOLD : ACCUM;
      end
      HOLD: state_n = out_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      len <= '0;
      sat <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      len <= len_n;
      sat <= sat_n;
    end
  end
endmodule
